// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC scan sequencer:
//   - adc_state_t     : sequencer FSM state encoding (also visible on the debug
//                       state output of the top module)
//   - CFG_* positions : bit positions inside the 6-bit ADC config word
//   - adc_cfg_word()  : builds the config word for a channel
//   - adc_lowest_ch() : lowest enabled channel of a mask
//   - adc_next_ch()   : lowest enabled channel strictly above the current one,
//                       wrapping to the lowest enabled channel
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;

  // Config word layout, MSB first: SD OS S1 S0 UNI SLP
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Channel 0, bipolar, single-ended, awake.
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQUEST    = 3'd1,
    ST_CONVERTING = 3'd2,
    ST_ACCUM      = 3'd3,
    ST_WAIT       = 3'd4
  } adc_state_t;

  // The ADC's channel select bits are not in natural order: OS carries
  // ch[0], S1 carries ch[2], S0 carries ch[1].
  function automatic logic [CFG_W-1:0] adc_cfg_word(input logic [2:0] ch,
                                                    input logic       uni);
    logic [CFG_W-1:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = uni;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

  function automatic logic [2:0] adc_lowest_ch(input logic [7:0] mask);
    logic [2:0] r;
    r = 3'd0;
    // Descending scan: the last hit is the lowest set bit.
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] adc_next_ch(input logic [7:0] mask,
                                             input logic [2:0] cur);
    logic [2:0] r;
    r = adc_lowest_ch(mask);
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) > cur)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_chan_avg.sv
// -----------------------------------------------------------------------------
// adc_chan_avg
// Per-channel accumulator bank. Each add folds one 12-bit sample into the
// accumulator of channel i_ch; when 2^AVG_LOG2 samples have been collected the
// truncated mean is presented for one clock and that channel restarts.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         clear every accumulator and count (sequencer idle)
//   i_add           add i_sample to channel i_ch this clock
//   i_ch            channel of the sample
//   i_sample        12-bit unsigned sample
//   o_valid         1-clk pulse, the clock after the completing add
//   o_channel       channel of the emitted mean (held until next emit)
//   o_data          emitted mean, acc >> AVG_LOG2 (truncating)
// -----------------------------------------------------------------------------
module adc_chan_avg
  import adc_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int AVG_LOG2     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_add,
  input  logic [2:0]          i_ch,
  input  logic [RESULT_W-1:0] i_sample,
  output logic                o_valid,
  output logic [2:0]          o_channel,
  output logic [RESULT_W-1:0] o_data
);

  localparam int ACC_W = RESULT_W + AVG_LOG2;
  // One extra bit so that AVG_LOG2 = 0 still has a legal (always-zero) count.
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]    r_acc [NUM_CHANNELS];
  logic [CNT_W-1:0]    r_cnt [NUM_CHANNELS];
  logic                r_valid;
  logic [2:0]          r_channel;
  logic [RESULT_W-1:0] r_data;

  logic [ACC_W-1:0]    w_sel_acc;
  logic [CNT_W-1:0]    w_sel_cnt;
  logic [ACC_W-1:0]    w_sum;
  logic                w_emit;

  always_comb begin
    w_sel_acc = '0;
    w_sel_cnt = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (i_ch == 3'(c)) begin
        w_sel_acc = r_acc[c];
        w_sel_cnt = r_cnt[c];
      end
    end
  end

  // ACC_W is wide enough for 2^AVG_LOG2 full-scale samples, so no overflow.
  assign w_sum  = w_sel_acc + ACC_W'(i_sample);
  assign w_emit = i_add && (w_sel_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (i_clear) begin
          r_acc[c] <= '0;
          r_cnt[c] <= '0;
        end else if (i_add && (i_ch == 3'(c))) begin
          if (w_emit) begin
            r_acc[c] <= '0;
            r_cnt[c] <= '0;
          end else begin
            r_acc[c] <= w_sum;
            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_channel <= '0;
      r_data    <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_channel <= i_ch;
        r_data    <= w_sum[ACC_W-1:AVG_LOG2];
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_channel = r_channel;
  assign o_data    = r_data;

endmodule

// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
// Walks the enabled ADC channels at a fixed sample period, drives the config
// word and conversion request into the ADC receiver, tags each returned word
// with the channel it belongs to (the ADC answers frame N with the config of
// frame N-1) and optionally averages per channel.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_enable                scan enable (level)
//   i_channel_mask[7:0]     bit c enables channel c (bits >= NUM_CHANNELS ignored)
//   i_unipolar              UNI bit of the config word
//   o_tx_bits[5:0]          config word to the receiver
//   o_request_conversion    conversion request to the receiver
//   i_conv_in_process       receiver has accepted the request
//   i_rx_dv, i_rx_data      receiver result strobe and data
//   o_result_valid/_channel/_data   tagged (averaged) result, 1-clk strobe
//   o_busy                  sequencer not idle
//   o_timeout_err           1-clk pulse when a conversion never returned
//   o_overrun               sticky: sample period expired mid-frame
//   o_dbg_state[2:0]        current FSM state (adc_state_t encoding)
//
// Request handshake: o_request_conversion is held high (with o_tx_bits stable)
// from REQUEST entry until the clock on which i_conv_in_process is seen high;
// that clock is the acceptance and the request drops on the next clock. The
// frame ends with a single-clock i_rx_dv, which is only accepted in CONVERTING.
// -----------------------------------------------------------------------------
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 5000,
  parameter int NUM_CHANNELS  = 8,
  parameter int AVG_LOG2      = 0,
  parameter int TIMEOUT_CLKS  = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [7:0]          i_channel_mask,
  input  logic                i_unipolar,
  output logic [5:0]          o_tx_bits,
  output logic                o_request_conversion,
  input  logic                i_conv_in_process,
  input  logic                i_rx_dv,
  input  logic [11:0]         i_rx_data,
  output logic                o_result_valid,
  output logic [2:0]          o_result_channel,
  output logic [11:0]         o_result_data,
  output logic                o_busy,
  output logic                o_timeout_err,
  output logic                o_overrun,
  output logic [2:0]          o_dbg_state
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]       CH_MASK    = 8'((16'd1 << NUM_CHANNELS) - 16'd1);
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CLKS - 1);

  adc_state_t          r_state;
  adc_state_t          w_next;

  logic [2:0]          r_cur_ch;
  logic [2:0]          r_pend_ch;
  logic                r_pend_vld;
  logic [5:0]          r_tx_bits;
  logic [PER_W-1:0]    r_period_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_overrun;
  logic                r_timeout_err;
  logic                r_en_d;
  logic [11:0]         r_rx_data;

  logic [7:0]          w_mask;
  logic [2:0]          w_first_ch;
  logic [2:0]          w_next_ch;
  logic                w_period_done;
  logic                w_to_hit;
  logic                w_timeout;
  logic                w_enter_req;
  logic                w_in_frame;
  logic                w_avg_add;
  logic                w_avg_clear;

  assign w_mask        = i_channel_mask & CH_MASK;
  assign w_first_ch    = adc_lowest_ch(w_mask);
  assign w_next_ch     = adc_next_ch(w_mask, r_cur_ch);
  // The period counter parks at zero once expired, so "done" stays true
  // until the next REQUEST entry reloads it.
  assign w_period_done = (r_period_cnt == '0);
  assign w_to_hit      = (r_to_cnt == TO_LAST);
  assign w_enter_req   = (w_next == ST_REQUEST) && (r_state != ST_REQUEST);
  assign w_in_frame    = (r_state == ST_REQUEST) || (r_state == ST_CONVERTING) ||
                         (r_state == ST_ACCUM);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (w_mask != 8'd0)) w_next = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (i_conv_in_process) begin
          w_next = ST_CONVERTING;
        end else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_CONVERTING: begin
        // A disable here is deliberately ignored: the receiver frame is
        // allowed to complete and the exit happens from WAIT.
        if (i_rx_dv) begin
          w_next = ST_ACCUM;
        end else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!i_enable)          w_next = ST_IDLE;
        else if (w_period_done) w_next = ST_REQUEST;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, channel pipeline, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_ch      <= '0;
      r_pend_ch     <= '0;
      r_pend_vld    <= 1'b0;
      r_tx_bits     <= CFG_RESET;
      r_period_cnt  <= '0;
      r_to_cnt      <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_en_d        <= 1'b0;
      r_rx_data     <= '0;
    end else begin
      r_en_d        <= i_enable;
      r_timeout_err <= w_timeout;

      // Reload on REQUEST entry so requests are exactly SAMPLE_PERIOD apart.
      if (w_enter_req)         r_period_cnt <= PER_RELOAD;
      else if (!w_period_done) r_period_cnt <= r_period_cnt - PER_W'(1);

      if (w_enter_req) begin
        r_to_cnt <= '0;
      end else if (((r_state == ST_REQUEST) || (r_state == ST_CONVERTING)) &&
                   !w_to_hit) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      // Falling enable clears; it wins over a same-clock set.
      if (r_en_d && !i_enable)          r_overrun <= 1'b0;
      else if (w_period_done && w_in_frame) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          // Re-prime: the first word after leaving IDLE answers a stale config.
          r_cur_ch   <= w_first_ch;
          r_tx_bits  <= adc_cfg_word(w_first_ch, i_unipolar);
          r_pend_vld <= 1'b0;
        end
        ST_CONVERTING: begin
          if (i_rx_dv) r_rx_data <= i_rx_data;
        end
        ST_ACCUM: begin
          // The config just sent (r_cur_ch) is what the next word answers.
          r_pend_ch  <= r_cur_ch;
          r_pend_vld <= 1'b1;
          r_cur_ch   <= w_next_ch;
          r_tx_bits  <= adc_cfg_word(w_next_ch, i_unipolar);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Averaging bank
  // ---------------------------------------------------------------------------
  assign w_avg_add   = (r_state == ST_ACCUM) && r_pend_vld;
  assign w_avg_clear = (r_state == ST_IDLE);

  adc_chan_avg #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .AVG_LOG2     (AVG_LOG2)
  ) u_avg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_avg_clear),
    .i_add     (w_avg_add),
    .i_ch      (r_pend_ch),
    .i_sample  (r_rx_data),
    .o_valid   (o_result_valid),
    .o_channel (o_result_channel),
    .o_data    (o_result_data)
  );

  assign o_tx_bits            = r_tx_bits;
  assign o_request_conversion = (r_state == ST_REQUEST);
  assign o_busy               = (r_state != ST_IDLE);
  assign o_timeout_err        = r_timeout_err;
  assign o_overrun            = r_overrun;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;
  import adc_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Three instances: [0] plain scan + timeout, [1] averaging, [2] overrun.
  logic [2:0]        en, uni, conv, dv;
  logic [2:0][7:0]   mask;
  logic [2:0][11:0]  rxd;
  logic [2:0][5:0]   tx;
  logic [2:0]        req, rv, busy, to_err, ovr;
  logic [2:0][2:0]   rch, st;
  logic [2:0][11:0]  rdata;

  adc_scan_sequencer #(.SAMPLE_PERIOD(200), .NUM_CHANNELS(8), .AVG_LOG2(0),
                       .TIMEOUT_CLKS(150)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_channel_mask(mask[0]),
    .i_unipolar(uni[0]), .o_tx_bits(tx[0]), .o_request_conversion(req[0]),
    .i_conv_in_process(conv[0]), .i_rx_dv(dv[0]), .i_rx_data(rxd[0]),
    .o_result_valid(rv[0]), .o_result_channel(rch[0]), .o_result_data(rdata[0]),
    .o_busy(busy[0]), .o_timeout_err(to_err[0]), .o_overrun(ovr[0]),
    .o_dbg_state(st[0]));

  adc_scan_sequencer #(.SAMPLE_PERIOD(200), .NUM_CHANNELS(8), .AVG_LOG2(2),
                       .TIMEOUT_CLKS(4096)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_channel_mask(mask[1]),
    .i_unipolar(uni[1]), .o_tx_bits(tx[1]), .o_request_conversion(req[1]),
    .i_conv_in_process(conv[1]), .i_rx_dv(dv[1]), .i_rx_data(rxd[1]),
    .o_result_valid(rv[1]), .o_result_channel(rch[1]), .o_result_data(rdata[1]),
    .o_busy(busy[1]), .o_timeout_err(to_err[1]), .o_overrun(ovr[1]),
    .o_dbg_state(st[1]));

  adc_scan_sequencer #(.SAMPLE_PERIOD(64), .NUM_CHANNELS(8), .AVG_LOG2(0),
                       .TIMEOUT_CLKS(4096)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_channel_mask(mask[2]),
    .i_unipolar(uni[2]), .o_tx_bits(tx[2]), .o_request_conversion(req[2]),
    .i_conv_in_process(conv[2]), .i_rx_dv(dv[2]), .i_rx_data(rxd[2]),
    .o_result_valid(rv[2]), .o_result_channel(rch[2]), .o_result_data(rdata[2]),
    .o_busy(busy[2]), .o_timeout_err(to_err[2]), .o_overrun(ovr[2]),
    .o_dbg_state(st[2]));

  // ---------------------------------------------------------------------------
  // Scoreboard: {instance[1:0], channel[2:0], data[11:0]}
  // ---------------------------------------------------------------------------
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  int          sb_rd = 0;
  int          errors = 0;
  int          checks = 0;

  always @(negedge clk) begin
    if (rv[0]) obs_q.push_back({2'd0, rch[0], rdata[0]});
    if (rv[1]) obs_q.push_back({2'd1, rch[1], rdata[1]});
    if (rv[2]) obs_q.push_back({2'd2, rch[2], rdata[2]});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = sb_rd; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, obs_q[i], exp_q[i]);
    sb_rd = exp_q.size();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (receiver model)
  // ---------------------------------------------------------------------------
  task automatic wait_req(input int k, input int limit, output int waited);
    waited = 0;
    while (!req[k] && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // One frame: wait for the request, check the config word, accept it, and
  // return data after conv_clks clocks. Returns on the negedge dv is cleared.
  task automatic serve(input int k, input logic [5:0] exp_tx, input int conv_clks,
                       input logic [11:0] data, output int t_req);
    int w;
    wait_req(k, 1000, w);
    chk("req_seen", {31'd0, req[k]}, 32'd1);
    t_req = cyc;
    chk("tx_bits_at_req", {26'd0, tx[k]}, {26'd0, exp_tx});
    conv[k] = 1'b1;
    repeat (conv_clks) @(negedge clk);
    dv[k]   = 1'b1;
    rxd[k]  = data;
    conv[k] = 1'b0;
    @(negedge clk);
    dv[k]   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t1, t2, t3, w;
    en = '0; uni = '0; conv = '0; dv = '0; mask = '0; rxd = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_bits", {26'd0, tx[0]}, 32'h20);
    chk("rst_req", {31'd0, req[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_result", {16'd0, rv[0], rch[0], rdata[0]}, 32'd0);
    chk("rst_status", {30'd0, to_err[0], ovr[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_req", {29'd0, req}, 32'd0);
    chk("idle_tx_bits", {26'd0, tx[2]}, 32'h20);

    // Scan of channels 0 and 2, first word discarded
    mask[0] = 8'b0000_0101;
    en[0]   = 1'b1;
    serve(0, 6'b100000, 100, 12'hA5A, t1);
    serve(0, 6'b100100, 100, 12'h111, t2);
    serve(0, 6'b100000, 100, 12'h222, t3);
    en[0] = 1'b0;
    chk("req_spacing_1", t2 - t1, 32'd200);
    chk("req_spacing_2", t3 - t2, 32'd200);
    exp_q.push_back({2'd0, 3'd0, 12'h111});
    exp_q.push_back({2'd0, 3'd2, 12'h222});
    repeat (5) @(negedge clk);
    chk("scan_back_idle", {29'd0, st[0]}, {29'd0, ST_IDLE});
    check_results("scan_result");

    // Averaging of four samples on channel 0
    mask[1] = 8'b0000_0001;
    en[1]   = 1'b1;
    serve(1, 6'b100000, 100, 12'h3FF, t1);
    serve(1, 6'b100000, 100, 12'h100, t1);
    serve(1, 6'b100000, 100, 12'h101, t1);
    serve(1, 6'b100000, 100, 12'h102, t1);
    serve(1, 6'b100000, 100, 12'h103, t1);
    en[1] = 1'b0;
    exp_q.push_back({2'd1, 3'd0, 12'h101});
    repeat (5) @(negedge clk);
    check_results("avg_result");

    // Timeout: no response from the receiver
    mask[0] = 8'b0000_0001;
    en[0]   = 1'b1;
    wait_req(0, 1000, w);
    chk("to_req_seen", {31'd0, req[0]}, 32'd1);
    t1 = cyc;
    w  = 0;
    while (!to_err[0] && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("to_pulse_seen", {31'd0, to_err[0]}, 32'd1);
    chk("to_latency", cyc - t1, 32'd150);
    chk("to_req_dropped", {31'd0, req[0]}, 32'd0);
    chk("to_state_idle", {29'd0, st[0]}, {29'd0, ST_IDLE});
    @(negedge clk);
    chk("to_pulse_width", {31'd0, to_err[0]}, 32'd0);
    serve(0, 6'b100000, 100, 12'h7FF, t1);
    serve(0, 6'b100000, 100, 12'h0AB, t1);
    en[0] = 1'b0;
    exp_q.push_back({2'd0, 3'd0, 12'h0AB});
    repeat (5) @(negedge clk);
    check_results("to_reprime");

    // Overrun: 100-clk conversions against a 64-clk period, channel 1 unipolar
    mask[2] = 8'b0000_0010;
    uni[2]  = 1'b1;
    en[2]   = 1'b1;
    serve(2, 6'b110010, 100, 12'h0FF, t1);
    chk("ovr_set", {31'd0, ovr[2]}, 32'd1);
    wait_req(2, 10, w);
    chk("ovr_back_to_back", w, 32'd2);
    serve(2, 6'b110010, 100, 12'h555, t1);
    chk("ovr_sticky", {31'd0, ovr[2]}, 32'd1);
    en[2] = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", {31'd0, ovr[2]}, 32'd0);
    exp_q.push_back({2'd2, 3'd1, 12'h555});
    repeat (5) @(negedge clk);
    chk("ovr_stays_clear", {31'd0, ovr[2]}, 32'd0);
    check_results("ovr_result");

    // Empty mask keeps the sequencer idle
    mask[0] = 8'h00;
    en[0]   = 1'b1;
    repeat (20) @(negedge clk);
    chk("mask0_busy", {31'd0, busy[0]}, 32'd0);
    chk("mask0_req", {31'd0, req[0]}, 32'd0);
    en[0] = 1'b0;

    // Asynchronous reset in the middle of a conversion
    mask[0] = 8'b0000_0100;
    en[0]   = 1'b1;
    wait_req(0, 1000, w);
    chk("ar_tx_before", {26'd0, tx[0]}, 32'h24);
    conv[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("ar_converting", {29'd0, st[0]}, {29'd0, ST_CONVERTING});
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy[0]}, 32'd0);
    chk("ar_req", {31'd0, req[0]}, 32'd0);
    chk("ar_tx_bits", {26'd0, tx[0]}, 32'h20);
    chk("ar_state", {29'd0, st[0]}, {29'd0, ST_IDLE});
    conv[0] = 1'b0;
    en[0]   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_results("final_results");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
